// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared widths and reset constants for the fetch/prefetch stage.
package fetch_prefetch_unit_pkg;
  localparam int A_BITS_DEF = 10;
  localparam int I_BITS_DEF = 16;
  localparam int RESET_PC   = 0;
endpackage

// File: rtl/fetch_prefetch_unit_fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {instruction, pc} pairs for decode.
module fetch_prefetch_unit_fetch_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head_data
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_data = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[PW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  // Storage is reset too so the head fields read zero out of reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: sequential request issue, in-order response
// capture into a prefetch queue, redirect/flush with in-flight discard.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int A_BITS = A_BITS_DEF,
  parameter int I_BITS = I_BITS_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              halt_op,
  input  logic              clr_sgn,
  input  logic              jmp_op,
  input  logic              jmp_relative_op,
  input  logic [A_BITS-1:0] jmp_val,
  input  logic [A_BITS-1:0] jmp_base,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [A_BITS-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [I_BITS-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [I_BITS-1:0] instr_out,
  output logic [A_BITS-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = I_BITS + A_BITS;

  logic [A_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [A_BITS-1:0] enq_pc_q, enq_pc_d;
  logic [A_BITS-1:0] deliver_pc_q, deliver_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_head;
  logic [CW:0]       in_use;
  logic [A_BITS-1:0] target;
  logic              redirect, accept, keep_rsp, pop;

  assign redirect = jmp_op | clr_sgn;
  assign in_use   = {1'b0, fifo_count} + {1'b0, outstanding_q};

  // nrst gates the request so it stays low while reset is held.
  assign imem_req_valid = nrst & ~halt_op & ~redirect & ~fifo_full
                        & (in_use < (CW+1)'(DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;
  assign keep_rsp       = imem_rsp_valid & (discard_q == '0) & ~redirect;
  assign instr_valid    = ~fifo_empty;
  assign pop            = instr_valid & instr_ready & ~halt_op & ~redirect;
  assign {instr_out, instr_pc} = fifo_head;

  always_comb begin
    target = jmp_val;
    if (!jmp_op)              target = deliver_pc_q;
    else if (jmp_relative_op) target = jmp_base + jmp_val;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    enq_pc_d      = enq_pc_q;
    deliver_pc_d  = deliver_pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    discard_d     = discard_q;
    if (redirect) begin
      fetch_pc_d   = target;
      enq_pc_d     = target;
      deliver_pc_d = target;
      // A response landing this cycle is dropped directly, not counted.
      discard_d    = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (accept)   fetch_pc_d   = fetch_pc_q + A_BITS'(1);
      if (keep_rsp) enq_pc_d     = enq_pc_q + A_BITS'(1);
      if (pop)      deliver_pc_d = instr_pc + A_BITS'(1);
      if (imem_rsp_valid && discard_q != '0) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fetch_pc_q    <= A_BITS'(RESET_PC);
      enq_pc_q      <= A_BITS'(RESET_PC);
      deliver_pc_q  <= A_BITS'(RESET_PC);
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      enq_pc_q      <= enq_pc_d;
      deliver_pc_q  <= deliver_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_prefetch_unit_fetch_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (keep_rsp),
    .push_data ({imem_rdata, enq_pc_q}),
    .pop       (pop),
    .flush     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (fifo_head)
  );
endmodule
